// File: rtl/displaymux_pkg.sv
// Shared constants and types for the seven-segment display source selector.
package displaymux_pkg;

  localparam int DIGIT_W       = 4;
  localparam int DWELL_DEFAULT = 50_000_000;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

endpackage

// File: rtl/displaymux_auto_if.sv
// Control/data bundle between the display-mux driver and the selector block.
interface displaymux_auto_if
  import displaymux_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DIGITS  = 8
);

  localparam int SEL_W = $clog2(NUM_SRC);

  logic [NUM_SRC*DIGITS*DIGIT_W-1:0] src_flat;
  logic [SEL_W-1:0]                  manual_sel;
  logic                              auto_en;
  logic                              freeze;
  logic                              blank_lz;
  logic [DIGITS*DIGIT_W-1:0]         digits_out;
  logic [DIGITS-1:0]                 digit_blank;
  logic [SEL_W-1:0]                  cur_sel;
  logic                              sel_change;

  modport master (
    output src_flat, manual_sel, auto_en, freeze, blank_lz,
    input  digits_out, digit_blank, cur_sel, sel_change
  );

  modport slave (
    input  src_flat, manual_sel, auto_en, freeze, blank_lz,
    output digits_out, digit_blank, cur_sel, sel_change
  );

endinterface

// File: rtl/lz_blanker.sv
// Combinational leading-zero mask: digit i blanks when it and every digit above
// it are zero; digit 0 always stays lit so an all-zero word shows a single 0.
module lz_blanker
  import displaymux_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic [DIGITS*DIGIT_W-1:0] word,
  input  logic                      blank_lz,
  output logic [DIGITS-1:0]         blank_mask
);

  logic upper_zero;

  always_comb begin
    blank_mask = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero & (word[i*DIGIT_W +: DIGIT_W] == '0);
      blank_mask[i] = blank_lz & upper_zero;
    end
  end

endmodule

// File: rtl/displaymux_auto.sv
// Picks one packed hex word for the display bank, manually or by dwell-timed
// rotation, and registers it with its leading-zero blank mask.
module displaymux_auto
  import displaymux_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DIGITS  = 8,
  parameter int DWELL   = DWELL_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  displaymux_auto_if.slave bus
);

  localparam int SEL_W  = $clog2(NUM_SRC);
  localparam int WORD_W = DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(DWELL);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SRC - 1);

  mode_e              mode;
  logic [SEL_W-1:0]   cur_sel, sel_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               sel_change;
  logic [WORD_W-1:0]  sel_word;
  logic [WORD_W-1:0]  digits_q;
  logic [DIGITS-1:0]  blank_mask, blank_q;

  assign sel_word = bus.src_flat[int'(cur_sel)*WORD_W +: WORD_W];

  lz_blanker #(.DIGITS(DIGITS)) u_lz_blanker (
    .word       (sel_word),
    .blank_lz   (bus.blank_lz),
    .blank_mask (blank_mask)
  );

  // Manual mode tracks manual_sel (out-of-range folds to 0) with the timer parked;
  // auto mode advances on terminal count unless frozen.
  always_comb begin
    mode    = bus.auto_en ? MODE_AUTO : MODE_MANUAL;
    sel_nxt = cur_sel;
    cnt_nxt = cnt;
    unique case (mode)
      MODE_MANUAL: begin
        cnt_nxt = '0;
        sel_nxt = (32'(bus.manual_sel) < NUM_SRC) ? bus.manual_sel : '0;
      end
      MODE_AUTO: begin
        if (!bus.freeze) begin
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            sel_nxt = (cur_sel == SEL_LAST) ? '0 : cur_sel + SEL_W'(1);
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        cnt_nxt = '0;
        sel_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_sel    <= '0;
      cnt        <= '0;
      sel_change <= 1'b0;
      digits_q   <= '0;
      blank_q    <= '0;
    end else begin
      cur_sel    <= sel_nxt;
      cnt        <= cnt_nxt;
      sel_change <= (sel_nxt != cur_sel);
      if (!bus.freeze) begin
        digits_q <= sel_word;
        blank_q  <= blank_mask;
      end
    end
  end

  assign bus.digits_out  = digits_q;
  assign bus.digit_blank = blank_q;
  assign bus.cur_sel     = cur_sel;
  assign bus.sel_change  = sel_change;

endmodule

// File: tb/tb_displaymux_auto.sv
// Directed bench for displaymux_auto with NUM_SRC=3, DIGITS=8, DWELL=4.
module tb_displaymux_auto;

  logic clk;
  logic resetn;
  logic [31:0] src [3];
  int checks;
  int errors;
  logic [1:0] exp_sel;
  logic [1:0] next_sel;

  displaymux_auto_if #(.NUM_SRC(3), .DIGITS(8)) dm_bus ();

  displaymux_auto #(.NUM_SRC(3), .DIGITS(8), .DWELL(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (dm_bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic auto, input logic frz, input logic blz);
    dm_bus.src_flat   = {src[2], src[1], src[0]};
    dm_bus.manual_sel = sel;
    dm_bus.auto_en    = auto;
    dm_bus.freeze     = frz;
    dm_bus.blank_lz   = blz;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    src[0] = 32'h0000_00A0;
    src[1] = 32'h0000_0000;
    src[2] = 32'h0000_1234;
    resetn = 1'b1;
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0);
    #3 resetn = 1'b0;
    tick(2);
    checkOutput("rst_sel", 64'(dm_bus.cur_sel), 64'd0);
    checkOutput("rst_digits", 64'(dm_bus.digits_out), 64'd0);
    checkOutput("rst_blank", 64'(dm_bus.digit_blank), 64'd0);
    checkOutput("rst_change", 64'(dm_bus.sel_change), 64'd0);

    // manual select of source 2
    resetn = 1'b1;
    applyStimulus(2'd2, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("man_sel", 64'(dm_bus.cur_sel), 64'd2);
    checkOutput("man_pulse", 64'(dm_bus.sel_change), 64'd1);
    tick(1);
    checkOutput("man_digits", 64'(dm_bus.digits_out), 64'h1234);
    checkOutput("man_pulse_end", 64'(dm_bus.sel_change), 64'd0);
    checkOutput("man_noblank", 64'(dm_bus.digit_blank), 64'd0);

    // leading-zero blanking
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("lz_1234", 64'(dm_bus.digit_blank), 64'hF0);
    tick(1);
    checkOutput("lz_a0_digits", 64'(dm_bus.digits_out), 64'hA0);
    checkOutput("lz_a0", 64'(dm_bus.digit_blank), 64'hFC);
    applyStimulus(2'd1, 1'b0, 1'b0, 1'b1);
    tick(2);
    checkOutput("lz_zero_digits", 64'(dm_bus.digits_out), 64'h0);
    checkOutput("lz_zero", 64'(dm_bus.digit_blank), 64'hFE);

    // out-of-range select folds to 0; rewriting same value gives no pulse
    applyStimulus(2'd3, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("oor_sel", 64'(dm_bus.cur_sel), 64'd0);
    checkOutput("oor_pulse", 64'(dm_bus.sel_change), 64'd1);
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("same_sel", 64'(dm_bus.cur_sel), 64'd0);
    checkOutput("same_nopulse", 64'(dm_bus.sel_change), 64'd0);

    // auto rotation 0 -> 1 -> 2 -> 0, four cycles per source
    applyStimulus(2'd2, 1'b1, 1'b0, 1'b1);
    exp_sel = 2'd0;
    for (int step = 0; step < 3; step++) begin
      next_sel = (exp_sel == 2'd2) ? 2'd0 : exp_sel + 2'd1;
      tick(1);
      checkOutput("auto_digits", 64'(dm_bus.digits_out), 64'(src[exp_sel]));
      checkOutput("auto_nopulse", 64'(dm_bus.sel_change), 64'd0);
      tick(2);
      checkOutput("auto_hold", 64'(dm_bus.cur_sel), 64'(exp_sel));
      tick(1);
      checkOutput("auto_step", 64'(dm_bus.cur_sel), 64'(next_sel));
      checkOutput("auto_pulse", 64'(dm_bus.sel_change), 64'd1);
      exp_sel = next_sel;
    end

    // freeze for 10 cycles two counts into the dwell
    tick(2);
    src[0] = 32'h0000_0005;
    applyStimulus(2'd2, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      checkOutput("frz_sel", 64'(dm_bus.cur_sel), 64'd0);
      checkOutput("frz_digits", 64'(dm_bus.digits_out), 64'hA0);
    end
    applyStimulus(2'd2, 1'b1, 1'b0, 1'b1);
    tick(1);
    checkOutput("thaw_sel", 64'(dm_bus.cur_sel), 64'd0);
    checkOutput("thaw_digits", 64'(dm_bus.digits_out), 64'h5);
    checkOutput("thaw_blank", 64'(dm_bus.digit_blank), 64'hFE);
    tick(1);
    checkOutput("thaw_step", 64'(dm_bus.cur_sel), 64'd1);
    checkOutput("thaw_pulse", 64'(dm_bus.sel_change), 64'd1);

    // freeze arriving exactly at terminal count
    tick(3);
    applyStimulus(2'd2, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick(1);
      checkOutput("tc_frz_sel", 64'(dm_bus.cur_sel), 64'd1);
      checkOutput("tc_frz_nopulse", 64'(dm_bus.sel_change), 64'd0);
    end
    applyStimulus(2'd2, 1'b1, 1'b0, 1'b1);
    tick(1);
    checkOutput("tc_step", 64'(dm_bus.cur_sel), 64'd2);
    checkOutput("tc_pulse", 64'(dm_bus.sel_change), 64'd1);

    // asynchronous reset mid-rotation
    tick(2);
    #2 resetn = 1'b0;
    #1;
    checkOutput("arst_sel", 64'(dm_bus.cur_sel), 64'd0);
    checkOutput("arst_digits", 64'(dm_bus.digits_out), 64'd0);
    checkOutput("arst_blank", 64'(dm_bus.digit_blank), 64'd0);
    checkOutput("arst_change", 64'(dm_bus.sel_change), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick(3);
    checkOutput("arst_hold", 64'(dm_bus.cur_sel), 64'd0);
    tick(1);
    checkOutput("arst_first_step", 64'(dm_bus.cur_sel), 64'd1);
    checkOutput("arst_pulse", 64'(dm_bus.sel_change), 64'd1);
    checkOutput("arst_digits_src0", 64'(dm_bus.digits_out), 64'h5);

    // freeze in manual mode: select follows, outputs hold
    applyStimulus(2'd2, 1'b0, 1'b1, 1'b1);
    tick(1);
    checkOutput("mfrz_sel", 64'(dm_bus.cur_sel), 64'd2);
    checkOutput("mfrz_pulse", 64'(dm_bus.sel_change), 64'd1);
    checkOutput("mfrz_digits", 64'(dm_bus.digits_out), 64'h5);
    tick(1);
    checkOutput("mfrz_digits_hold", 64'(dm_bus.digits_out), 64'h5);
    applyStimulus(2'd2, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("mthaw_digits", 64'(dm_bus.digits_out), 64'h1234);
    checkOutput("mthaw_blank", 64'(dm_bus.digit_blank), 64'hF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/displaymux_auto.md
# displaymux_auto

Parametrised source selector for the seven-segment hex display bank. It selects one of `NUM_SRC` packed hex words, either from a manual select or by auto-rotating on a dwell timer. The selected word is registered into `DIGITS` nibble outputs, with optional freeze and leading-zero blanking. It sits between the calculator register file/ALU and the per-digit hex-to-segment decoders.

## Interface
Parameters:
- `NUM_SRC`, 4: number of source words; ≥2.
- `DIGITS`, 8: nibbles per word and per output; ≥1.
- `DWELL`, 50_000_000: cycles per source in auto mode; ≥2.
- `SEL_W`, `$clog2(NUM_SRC)`: select width; derived, not overridden.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`, in, 1: system clock; all state on rising edge.
  - `resetn`, in, 1: asynchronous, active-low reset.
- Inputs:
  - `src_flat`, in, `NUM_SRC*DIGITS*4`: source k occupies bits `[k*DIGITS*4 +: DIGITS*4]`.
  - `manual_sel`, in, `SEL_W`: source index used in manual mode.
  - `auto_en`, in, 1: 1 = auto-rotate, 0 = manual.
  - `freeze`, in, 1: hold outputs and pause the dwell counter.
  - `blank_lz`, in, 1: enable leading-zero blanking.
- Outputs:
  - `digits_out`, out, `DIGITS*4`: nibble i at `[4*i +: 4]`; i=0 is least significant.
  - `digit_blank`, out, `DIGITS`: 1 = decoder must blank digit i.
  - `cur_sel`, out, `SEL_W`: currently selected source index.
  - `sel_change`, out, 1: one-cycle pulse when `cur_sel` changes.

## Operation
- Reset values: `cur_sel`=0, dwell counter=0, `digits_out`=0, `digit_blank`=0, `sel_change`=0.
- Manual mode (`auto_en`=0):
  - `cur_sel` <= `manual_sel` every cycle.
  - `manual_sel` ≥ `NUM_SRC` maps to 0.
  - Dwell counter held at 0.
- Auto mode (`auto_en`=1):
  - Counter counts 0..`DWELL`-1.
  - At `DWELL`-1: counter <= 0, `cur_sel` <= `cur_sel`+1, wrapping `NUM_SRC`-1 -> 0.
  - `manual_sel` is ignored.
- Mode change:
  - Manual->auto: rotation starts from the present `cur_sel`, counter starts at 0.
  - Auto->manual: `cur_sel` <= `manual_sel` on the next edge.
- Freeze (`freeze`=1):
  - `digits_out`, `digit_blank` and the counter hold.
  - `cur_sel` still follows `manual_sel` in manual mode but does not advance in auto mode.
  - On release, outputs resample on the next edge.
- Output register: when not frozen, `digits_out` <= source[`cur_sel`] each cycle.
- Blanking: `digit_blank[i]`=1 iff all of the following hold:
  - `blank_lz`=1;
  - i ≥ 1;
  - nibbles i..`DIGITS`-1 of the word being registered are all zero.
- Digit 0 is never blanked; an all-zero word displays a single "0".
- `digit_blank` is registered with, and always consistent with, `digits_out`.
- `sel_change`: 1 for exactly one cycle after any edge where `cur_sel` took a new value. It is 0 when the written value equals the old one.

## Timing
- `manual_sel` change at edge N: `cur_sel` updates at edge N+1; `digits_out` reflects the new source at edge N+2.
- Source data change: visible on `digits_out` one edge later when not frozen.
- Auto rotation: `cur_sel` advances every `DWELL` unfrozen cycles.
- Freeze pauses the count without resetting it.
- Reset asserted mid-rotation: all state clears immediately (asynchronous). After deassertion, the first advance occurs `DWELL` cycles later.
- Terminal count coinciding with `freeze` rising: freeze wins; no advance, counter holds at `DWELL`-1.

## Structure
- `displaymux_pkg`: `DIGIT_W`=4 and the default `DWELL` constant.
- Sub-module `lz_blanker`: purely combinational leading-zero mask, parametrised on `DIGITS`, taking a word and `blank_lz`. Reused by future display blocks.
- Top level holds the select register, dwell counter, output/blank registers and edge detector.

## Test plan
- Reset, then manual_sel=2 with src2=32'h0000_1234 -> `cur_sel`=2 at edge+1, `digits_out`=32'h0000_1234 at edge+2, `sel_change` pulses once.
- blank_lz=1 with src=32'h0000_00A0 -> `digit_blank`=8'b1111_1100; src=0 -> 8'b1111_1110.
- Auto mode, DWELL=4, NUM_SRC=3 -> `cur_sel` sequence 0,1,2,0 every 4 cycles; `sel_change` pulses on each step.
- Auto mode with freeze held 10 cycles mid-dwell -> `cur_sel` and `digits_out` constant; advance resumes with the remaining count.
- manual_sel=3 with NUM_SRC=3 -> `cur_sel`=0.
- Reset asserted mid-rotation -> all outputs 0 asynchronously; first advance `DWELL` cycles after release.
